// File: rtl/sn74xx_scan_mux.sv
// Registered CHANNELS-to-1 word multiplexer with manual select or a dwell-timed scan sequencer.
// Define SN74XX_SCAN_MUX_HOLD_EN to hold `out` while strobed off instead of clearing it.
module sn74xx_scan_mux #(
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned DWELL    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH*CHANNELS-1:0] din,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      str_n,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      valid,
  output logic                      frame
);

  localparam int unsigned DcW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [WIDTH-1:0] out_q, out_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             valid_q, valid_d;
  logic             frame_q, frame_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [DcW-1:0]   dc_q, dc_d;

  // Indices at or above CHANNELS select nothing and yield zero.
  function automatic logic [WIDTH-1:0] pick(input logic [SEL_W-1:0] idx,
                                            input logic [WIDTH*CHANNELS-1:0] data);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (idx == SEL_W'(k)) r = data[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  always_comb begin
    out_d    = out_q;
    out_ch_d = out_ch_q;
    valid_d  = 1'b0;
    frame_d  = 1'b0;
    ch_d     = ch_q;
    dc_d     = dc_q;
    if (str_n) begin
`ifdef SN74XX_SCAN_MUX_HOLD_EN
      out_d = out_q;
`else
      out_d = '0;
`endif
    end else if (!mode) begin
      out_d    = pick(sel, din);
      out_ch_d = sel;
      valid_d  = 1'b1;
      ch_d     = '0;
      dc_d     = '0;
    end else begin
      out_d    = pick(ch_q, din);
      out_ch_d = ch_q;
      valid_d  = (dc_q == '0);
      frame_d  = (dc_q == '0) && (ch_q == '0);
      if (dc_q == DcW'(DWELL - 1)) begin
        dc_d = '0;
        ch_d = (ch_q == SEL_W'(CHANNELS - 1)) ? '0 : ch_q + SEL_W'(1);
      end else begin
        dc_d = dc_q + DcW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q    <= '0;
      out_ch_q <= '0;
      valid_q  <= 1'b0;
      frame_q  <= 1'b0;
      ch_q     <= '0;
      dc_q     <= '0;
    end else begin
      out_q    <= out_d;
      out_ch_q <= out_ch_d;
      valid_q  <= valid_d;
      frame_q  <= frame_d;
      ch_q     <= ch_d;
      dc_q     <= dc_d;
    end
  end

  assign out    = out_q;
  assign out_ch = out_ch_q;
  assign valid  = valid_q;
  assign frame  = frame_q;

endmodule

// File: tb/tb_sn74xx_scan_mux.sv
// Scoreboard bench for sn74xx_scan_mux with WIDTH=2, CHANNELS=4, DWELL=2.
module tb_sn74xx_scan_mux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic [1:0] sel;
  logic       str_n;
  logic       mode;
  logic [1:0] out;
  logic [1:0] out_ch;
  logic       valid;
  logic       frame;

  typedef struct {
    string      name;
    logic [1:0] o;
    logic [1:0] c;
    logic       v;
    logic       f;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  sn74xx_scan_mux #(
    .WIDTH   (2),
    .CHANNELS(4),
    .SEL_W   (2),
    .DWELL   (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .sel   (sel),
    .str_n (str_n),
    .mode  (mode),
    .out   (out),
    .out_ch(out_ch),
    .valid (valid),
    .frame (frame)
  );

  always #5 clk = ~clk;

`ifdef SN74XX_SCAN_MUX_HOLD_EN
  localparam logic [1:0] PauseOut = 2'd1;
`else
  localparam logic [1:0] PauseOut = 2'd0;
`endif

  // Drive inputs on the falling edge, queue the response expected after the next rising edge.
  task automatic step(input string nm, input logic r, input logic s, input logic m,
                      input logic [1:0] sl, input logic [1:0] eo, input logic [1:0] ec,
                      input logic ev, input logic ef);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    str_n = s;
    mode  = m;
    sel   = sl;
    @(posedge clk);
    e.name = nm;
    e.o = eo;
    e.c = ec;
    e.v = ev;
    e.f = ef;
    exp_q.push_back(e);
  endtask

  // Monitor: every output sample is compared against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (out !== e.o || out_ch !== e.c || valid !== e.v || frame !== e.f) begin
          errors++;
          $display("FAIL %s: got out=%0d out_ch=%0d valid=%0b frame=%0b, want out=%0d out_ch=%0d valid=%0b frame=%0b",
                   e.name, out, out_ch, valid, frame, e.o, e.c, e.v, e.f);
        end
      end
    end
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL timeout: simulation did not complete, got running want finished");
      $fatal(1, "timeout");
    end
  end

  initial begin
    din   = 8'b00_01_10_11;
    rst_n = 1'b0;
    str_n = 1'b0;
    mode  = 1'b1;
    sel   = 2'd0;

    // Reset held two cycles, then first scan edge.
    step("reset0",   0, 0, 1, 0, 2'd0, 2'd0, 0, 0);
    step("reset1",   0, 0, 1, 0, 2'd0, 2'd0, 0, 0);
    step("rst_rel",  1, 0, 1, 0, 2'd3, 2'd0, 1, 1);

    // Manual select.
    step("man0",     1, 0, 0, 0, 2'd3, 2'd0, 1, 0);
    step("man1",     1, 0, 0, 1, 2'd2, 2'd1, 1, 0);
    step("man2",     1, 0, 0, 2, 2'd1, 2'd2, 1, 0);
    step("man3",     1, 0, 0, 3, 2'd0, 2'd3, 1, 0);

    // Ten scan cycles from channel 0.
    step("scan1",    1, 0, 1, 0, 2'd3, 2'd0, 1, 1);
    step("scan2",    1, 0, 1, 0, 2'd3, 2'd0, 0, 0);
    step("scan3",    1, 0, 1, 0, 2'd2, 2'd1, 1, 0);
    step("scan4",    1, 0, 1, 0, 2'd2, 2'd1, 0, 0);
    step("scan5",    1, 0, 1, 0, 2'd1, 2'd2, 1, 0);
    step("scan6",    1, 0, 1, 0, 2'd1, 2'd2, 0, 0);
    step("scan7",    1, 0, 1, 0, 2'd0, 2'd3, 1, 0);
    step("scan8",    1, 0, 1, 0, 2'd0, 2'd3, 0, 0);
    step("scan9",    1, 0, 1, 0, 2'd3, 2'd0, 1, 1);
    step("scan10",   1, 0, 1, 0, 2'd3, 2'd0, 0, 0);

    // Advance to the channel-2 valid sample, then pause three cycles.
    step("pre_p1",   1, 0, 1, 0, 2'd2, 2'd1, 1, 0);
    step("pre_p2",   1, 0, 1, 0, 2'd2, 2'd1, 0, 0);
    step("pre_p3",   1, 0, 1, 0, 2'd1, 2'd2, 1, 0);
    step("pause1",   1, 1, 1, 0, PauseOut, 2'd2, 0, 0);
    step("pause2",   1, 1, 1, 0, PauseOut, 2'd2, 0, 0);
    step("pause3",   1, 1, 1, 0, PauseOut, 2'd2, 0, 0);
    step("resume1",  1, 0, 1, 0, 2'd1, 2'd2, 0, 0);
    step("resume2",  1, 0, 1, 0, 2'd0, 2'd3, 1, 0);

    // Reset mid-scan at channel 3, then restart.
    step("rst_mid",  0, 0, 1, 0, 2'd0, 2'd0, 0, 0);
    step("restart1", 1, 0, 1, 0, 2'd3, 2'd0, 1, 1);
    step("restart2", 1, 0, 1, 0, 2'd3, 2'd0, 0, 0);
    step("restart3", 1, 0, 1, 0, 2'd2, 2'd1, 1, 0);
    step("restart4", 1, 0, 1, 0, 2'd2, 2'd1, 0, 0);
    step("restart5", 1, 0, 1, 0, 2'd1, 2'd2, 1, 0);

    // Mode switch mid-scan to manual sel=1, then back to scan.
    step("msw_man",  1, 0, 0, 1, 2'd2, 2'd1, 1, 0);
    step("msw_scn1", 1, 0, 1, 1, 2'd3, 2'd0, 1, 1);
    step("msw_scn2", 1, 0, 1, 1, 2'd3, 2'd0, 0, 0);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
